// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Integer register file for the single-cycle RISC-V core. Supplies the ALU
// operands and absorbs the ALU result as write-back data.
//
// 32 architectural registers x0..x31; x0 has no storage and always reads 0.
// Two combinational read ports with write-first bypass, one synchronous
// write port, and a debug read port that returns stored contents only.
//
// Parameters:
//   XLEN      register / data width in bits
//   NREGS     number of registers (address width is log2(NREGS) = 5)
//
// Ports:
//   clk       rising-edge clock for all state updates
//   rst       synchronous active-high reset, clears x1..x31, blocks writes
//   rs1_addr  read port 1 address      rs1_data  read port 1 data (ALU in_a)
//   rs2_addr  read port 2 address      rs2_data  read port 2 data (ALU in_b)
//   rd_wr_en  write-back enable
//   rd_addr   write-back destination   rd_data   write-back data (alu_out)
//   dbg_addr  debug read address       dbg_data  stored contents, no bypass
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rd_wr_en,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    // Storage only for x1..x(NREGS-1); x0 is synthesised as a constant.
    logic [XLEN-1:0] regs [1:NREGS-1];

    // A write is committed only outside reset and never to x0.
    logic wr_commit;
    assign wr_commit = rd_wr_en && (rd_addr != 5'd0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[rd_addr] <= rd_data;
        end
    end

    // Read port 1: reset and x0 force zero ahead of the bypass compare, so a
    // pending write to x0 can never leak onto the operand bus.
    always_comb begin
        rs1_data = '0;
        if (!rst && rs1_addr != 5'd0) begin
            if (rd_wr_en && rd_addr == rs1_addr) begin
                rs1_data = rd_data;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    // Read port 2: same structure as port 1, evaluated independently.
    always_comb begin
        rs2_data = '0;
        if (!rst && rs2_addr != 5'd0) begin
            if (rd_wr_en && rd_addr == rs2_addr) begin
                rs2_data = rd_data;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    // Debug port deliberately skips the bypass so benches observe what the
    // flops actually hold.
    always_comb begin
        dbg_data = '0;
        if (!rst && dbg_addr != 5'd0) begin
            dbg_data = regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Directed self-checking bench for reg_file: reset clear, write/read,
// x0 immutability, bypass, reset-over-write, back-to-back writes and a full
// address sweep on all three read ports.
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int compared   = 0;
    int mismatched = 0;

    reg_file #(.XLEN(32), .NREGS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_wr_en (rd_wr_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        rd_wr_en = 1'b1;
        rd_addr  = a;
        rd_data  = d;
        tick();
        rd_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_reg(5'd5, 32'hDEADBEEF);
        dbg_addr = 5'd5;
        #1;
        compared++;
        if (dbg_data !== 32'hDEADBEEF) begin
            $display("FAIL reset_preload: got %h expected %h", dbg_data, 32'hDEADBEEF);
            mismatched++;
        end
        rst = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd5;
        #1;
        compared++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL reset_rs1_during: got %h expected %h", rs1_data, 32'h0);
            mismatched++;
        end
        compared++;
        if (rs2_data !== 32'h0) begin
            $display("FAIL reset_rs2_during: got %h expected %h", rs2_data, 32'h0);
            mismatched++;
        end
        compared++;
        if (dbg_data !== 32'h0) begin
            $display("FAIL reset_dbg_during: got %h expected %h", dbg_data, 32'h0);
            mismatched++;
        end
        tick();
        rst = 1'b0;
        #1;
        compared++;
        if (dbg_data !== 32'h0) begin
            $display("FAIL reset_dbg_after: got %h expected %h", dbg_data, 32'h0);
            mismatched++;
        end
        compared++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL reset_rs1_after: got %h expected %h", rs1_data, 32'h0);
            mismatched++;
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd3, 32'hAAAA5555);
        write_reg(5'd4, 32'h5555AAAA);
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        compared++;
        if (rs1_data !== 32'hAAAA5555) begin
            $display("FAIL wr_rs1_x3: got %h expected %h", rs1_data, 32'hAAAA5555);
            mismatched++;
        end
        compared++;
        if (rs2_data !== 32'h5555AAAA) begin
            $display("FAIL wr_rs2_x4: got %h expected %h", rs2_data, 32'h5555AAAA);
            mismatched++;
        end
        // Disabled write must leave x3 alone.
        rd_wr_en = 1'b0;
        rd_addr  = 5'd3;
        rd_data  = 32'h01234567;
        #1;
        compared++;
        if (rs1_data !== 32'hAAAA5555) begin
            $display("FAIL wr_disabled_bypass: got %h expected %h", rs1_data, 32'hAAAA5555);
            mismatched++;
        end
        tick();
        dbg_addr = 5'd3;
        #1;
        compared++;
        if (dbg_data !== 32'hAAAA5555) begin
            $display("FAIL wr_disabled_store: got %h expected %h", dbg_data, 32'hAAAA5555);
            mismatched++;
        end
    endtask

    task automatic test_x0();
        rd_wr_en = 1'b1;
        rd_addr  = 5'd0;
        rd_data  = 32'hFFFFFFFF;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        dbg_addr = 5'd0;
        #1;
        compared++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL x0_rs1_write_cycle: got %h expected %h", rs1_data, 32'h0);
            mismatched++;
        end
        compared++;
        if (rs2_data !== 32'h0) begin
            $display("FAIL x0_rs2_write_cycle: got %h expected %h", rs2_data, 32'h0);
            mismatched++;
        end
        tick();
        rd_wr_en = 1'b0;
        #1;
        compared++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL x0_rs1_after: got %h expected %h", rs1_data, 32'h0);
            mismatched++;
        end
        compared++;
        if (dbg_data !== 32'h0) begin
            $display("FAIL x0_dbg_after: got %h expected %h", dbg_data, 32'h0);
            mismatched++;
        end
    endtask

    task automatic test_bypass();
        write_reg(5'd7, 32'h00000001);
        rd_wr_en = 1'b1;
        rd_addr  = 5'd7;
        rd_data  = 32'h12345678;
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        dbg_addr = 5'd7;
        #1;
        compared++;
        if (rs1_data !== 32'h12345678) begin
            $display("FAIL byp_rs1: got %h expected %h", rs1_data, 32'h12345678);
            mismatched++;
        end
        compared++;
        if (rs2_data !== 32'h12345678) begin
            $display("FAIL byp_rs2: got %h expected %h", rs2_data, 32'h12345678);
            mismatched++;
        end
        compared++;
        if (dbg_data !== 32'h00000001) begin
            $display("FAIL byp_dbg_before: got %h expected %h", dbg_data, 32'h00000001);
            mismatched++;
        end
        tick();
        rd_wr_en = 1'b0;
        #1;
        compared++;
        if (dbg_data !== 32'h12345678) begin
            $display("FAIL byp_dbg_after: got %h expected %h", dbg_data, 32'h12345678);
            mismatched++;
        end
    endtask

    task automatic test_reset_beats_write();
        write_reg(5'd9, 32'h11111111);
        rst      = 1'b1;
        rd_wr_en = 1'b1;
        rd_addr  = 5'd9;
        rd_data  = 32'hCAFEF00D;
        rs1_addr = 5'd9;
        #1;
        compared++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL rbw_rs1_during: got %h expected %h", rs1_data, 32'h0);
            mismatched++;
        end
        tick();
        rst      = 1'b0;
        rd_wr_en = 1'b0;
        dbg_addr = 5'd9;
        #1;
        compared++;
        if (dbg_data !== 32'h0) begin
            $display("FAIL rbw_dbg_after: got %h expected %h", dbg_data, 32'h0);
            mismatched++;
        end
        compared++;
        if (rs1_data !== 32'h0) begin
            $display("FAIL rbw_rs1_after: got %h expected %h", rs1_data, 32'h0);
            mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        write_reg(5'd10, 32'h0000AAAA);
        rd_wr_en = 1'b1;
        rd_addr  = 5'd10;
        rd_data  = 32'h0000BBBB;
        rs1_addr = 5'd10;
        dbg_addr = 5'd10;
        #1;
        compared++;
        if (rs1_data !== 32'h0000BBBB) begin
            $display("FAIL b2b_rs1_bypass: got %h expected %h", rs1_data, 32'h0000BBBB);
            mismatched++;
        end
        compared++;
        if (dbg_data !== 32'h0000AAAA) begin
            $display("FAIL b2b_dbg_first: got %h expected %h", dbg_data, 32'h0000AAAA);
            mismatched++;
        end
        tick();
        rd_wr_en = 1'b0;
        #1;
        compared++;
        if (dbg_data !== 32'h0000BBBB) begin
            $display("FAIL b2b_dbg_last: got %h expected %h", dbg_data, 32'h0000BBBB);
            mismatched++;
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp1;
        logic [31:0] exp2;
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(32 - i);
            dbg_addr = 5'(i);
            exp1 = 32'(i) * 32'h01010101;
            exp2 = 32'(32 - i) * 32'h01010101;
            #1;
            compared++;
            if (rs1_data !== exp1) begin
                $display("FAIL sweep_rs1 x%0d: got %h expected %h", i, rs1_data, exp1);
                mismatched++;
            end
            compared++;
            if (rs2_data !== exp2) begin
                $display("FAIL sweep_rs2 x%0d: got %h expected %h", 32 - i, rs2_data, exp2);
                mismatched++;
            end
            compared++;
            if (dbg_data !== exp1) begin
                $display("FAIL sweep_dbg x%0d: got %h expected %h", i, dbg_data, exp1);
                mismatched++;
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        rd_wr_en = 1'b0;
        rd_addr  = '0;
        rd_data  = '0;
        dbg_addr = '0;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_reset_beats_write();
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
